// File: rtl/jtframe_cen_pkg.sv
// Shared definitions for the fractional clock-enable controller.
//  - state_t    : controller state {OFF, RUN, PEND}
//  - STEP_357 / LIM_357 : default pair, 48 MHz * 105/1408 = 3.579545 MHz
//  - acc_illegal: true when the accumulator lies outside its reachable
//                 range (acc >= lim + step) and must be recovered
package jtframe_cen_pkg;

  typedef enum logic [1:0] {
    OFF  = 2'd0,
    RUN  = 2'd1,
    PEND = 2'd2
  } state_t;

  localparam int STEP_357  = 105;
  localparam int LIM_357   = 1408;
  localparam int CEN_CNT_W = 16;

  // Operands are zero-extended to 32 bits by the caller, so the sum
  // cannot overflow for any accumulator width this block is built with.
  function automatic logic acc_illegal(input int unsigned acc,
                                       input int unsigned step,
                                       input int unsigned lim);
    return acc >= (step + lim);
  endfunction

endpackage

// File: rtl/jtframe_frac_cen_ctl_if.sv
// Control/status bundle of jtframe_frac_cen_ctl.
//  master : register file / OSD side (drives enable and config)
//  slave  : the controller (drives cen, cen_half, status and state)
// Signals: enable, cfg_we, cfg_step[W], cfg_lim[W] -> controller
//          cfg_busy, cfg_err, cen, cen_half, cen_cnt[16], state -> master
//
// Config handshake: cfg_we is the valid strobe and !cfg_busy is ready.
// A write transfers on a cycle with cfg_we=1 and cfg_busy=0; cfg_step and
// cfg_lim are sampled on that edge. A transferred pair that fails
// validation (step==0 or step>lim) is dropped and cfg_err pulses for one
// cycle. cfg_we while cfg_busy=1 is not a transfer and is silently ignored.
interface jtframe_frac_cen_ctl_if #(
  parameter int W = 11
);
  import jtframe_cen_pkg::*;

  logic                 enable;
  logic                 cfg_we;
  logic [W-1:0]         cfg_step;
  logic [W-1:0]         cfg_lim;
  logic                 cfg_busy;
  logic                 cfg_err;
  logic                 cen;
  logic                 cen_half;
  logic [CEN_CNT_W-1:0] cen_cnt;
  state_t               state;   // debug view of the controller FSM

  modport master (
    output enable, cfg_we, cfg_step, cfg_lim,
    input  cfg_busy, cfg_err, cen, cen_half, cen_cnt, state
  );

  modport slave (
    input  enable, cfg_we, cfg_step, cfg_lim,
    output cfg_busy, cfg_err, cen, cen_half, cen_cnt, state
  );

endinterface

// File: rtl/jtframe_frac_acc.sv
// Phase accumulator for the fractional clock enable.
// Each cycle with run=1 the accumulator advances by step; when it reaches
// lim it wraps (keeping the remainder) and wrap is raised in the same cycle.
// An accumulator found at or above lim+step (possible after a config change
// keeps a large remainder) is cleared and also reported as a wrap.
//  clk, rst : clock, asynchronous active-high reset
//  step, lim: current configuration (W bits)
//  run      : advance this cycle
//  clr      : force accumulator to zero (takes priority over run)
//  wrap     : combinational, this cycle's update is a wrap
//  acc      : accumulator value (W+1 bits)
module jtframe_frac_acc
  import jtframe_cen_pkg::*;
#(
  parameter int W = 11
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] step,
  input  logic [W-1:0] lim,
  input  logic         run,
  input  logic         clr,
  output logic         wrap,
  output logic [W:0]   acc
);

  // One extra bit over acc so acc+step never overflows.
  logic [W+1:0] nxt;
  logic [W+1:0] sub;
  logic         rec;
  logic         hit;

  assign nxt  = {1'b0, acc} + {2'b00, step};
  assign sub  = nxt - {2'b00, lim};
  assign rec  = acc_illegal(32'(acc), 32'(step), 32'(lim));
  assign hit  = nxt >= {2'b00, lim};
  assign wrap = run && (rec || hit);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc <= '0;
    end else if (clr) begin
      acc <= '0;
    end else if (run) begin
      if (rec) begin
        acc <= '0;
      end else if (hit) begin
        acc <= sub[W:0];
      end else begin
        acc <= nxt[W:0];
      end
    end
  end

endmodule

// File: rtl/jtframe_frac_cen_ctl.sv
// Run-time reconfigurable fractional clock-enable controller.
// Average cen rate is f_clk*step/lim; cen_half marks every second cen.
// New step/lim pairs are staged in shadow registers and applied on a wrap
// so no output period is cut short or stretched by a reconfiguration.
//  clk  : system clock
//  rst  : asynchronous active-high reset (restores STEP0/LIM0, drops any
//         staged config)
//  bus  : jtframe_frac_cen_ctl_if.slave (enable, config handshake, cen,
//         cen_half, cen_cnt, state)
// Build option: JTFRAME_FRAC_CEN_STAT_EN adds a saturating count of cen
// pulses since the last config apply; without it cen_cnt is constant 0.
module jtframe_frac_cen_ctl
  import jtframe_cen_pkg::*;
#(
  parameter int W     = 11,
  parameter int STEP0 = STEP_357,
  parameter int LIM0  = LIM_357
) (
  input logic                   clk,
  input logic                   rst,
  jtframe_frac_cen_ctl_if.slave bus
);

  state_t       state;
  logic [W-1:0] step, lim;
  logic [W-1:0] sh_step, sh_lim;
  logic [W-1:0] new_step, new_lim;
  logic [W:0]   acc;
  logic         run, clr, wrap, rec, cfg_ok, apply;
  logic         alt, cen_q, half_q, busy_q, err_q;

  // The accumulator only advances while running and enabled; dropping
  // enable clears the phase in the same edge that moves the FSM to OFF.
  assign run    = bus.enable && (state != OFF);
  assign clr    = !run;
  assign rec    = acc_illegal(32'(acc), 32'(step), 32'(lim));
  assign cfg_ok = (bus.cfg_step != '0) && (bus.cfg_step <= bus.cfg_lim);

  jtframe_frac_acc #(.W(W)) u_acc (
    .clk  (clk),
    .rst  (rst),
    .step (step),
    .lim  (lim),
    .run  (run),
    .clr  (clr),
    .wrap (wrap),
    .acc  (acc)
  );

  // Config is written straight into step/lim when the accumulator is (or is
  // about to be) idle, otherwise from the shadow on the wrap that ends the
  // current period. The wrap itself still uses the old pair, so the
  // remainder carried into the new configuration is the old one.
  always_comb begin
    apply    = 1'b0;
    new_step = bus.cfg_step;
    new_lim  = bus.cfg_lim;
    case (state)
      OFF:  apply = bus.cfg_we && cfg_ok;
      RUN:  apply = !bus.enable && bus.cfg_we && cfg_ok;
      PEND: begin
        apply    = !bus.enable || wrap;
        new_step = sh_step;
        new_lim  = sh_lim;
      end
      default: apply = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= OFF;
      step    <= W'(STEP0);
      lim     <= W'(LIM0);
      sh_step <= '0;
      sh_lim  <= '0;
      alt     <= 1'b0;
      cen_q   <= 1'b0;
      half_q  <= 1'b0;
      busy_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      cen_q  <= wrap;
      half_q <= wrap && alt;
      err_q  <= 1'b0;
      // A recovery wrap restarts the half-rate phase from zero.
      if (!run) begin
        alt <= 1'b0;
      end else if (wrap) begin
        alt <= rec ? 1'b0 : ~alt;
      end
      if (apply) begin
        step <= new_step;
        lim  <= new_lim;
      end
      case (state)
        OFF: begin
          if (bus.cfg_we && !cfg_ok) err_q <= 1'b1;
          if (bus.enable) state <= RUN;
        end
        RUN: begin
          if (bus.cfg_we && !cfg_ok) err_q <= 1'b1;
          if (!bus.enable) begin
            state <= OFF;
          end else if (bus.cfg_we && cfg_ok) begin
            sh_step <= bus.cfg_step;
            sh_lim  <= bus.cfg_lim;
            busy_q  <= 1'b1;
            state   <= PEND;
          end
        end
        PEND: begin
          if (apply) begin
            busy_q <= 1'b0;
            state  <= bus.enable ? RUN : OFF;
          end
        end
        default: begin
          busy_q <= 1'b0;
          state  <= OFF;
        end
      endcase
    end
  end

`ifdef JTFRAME_FRAC_CEN_STAT_EN
  logic [CEN_CNT_W-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (!run || apply) begin
      cnt <= '0;
    end else if (wrap && (cnt != '1)) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign bus.cen_cnt = cnt;
`else
  assign bus.cen_cnt = '0;
`endif

  assign bus.cen      = cen_q;
  assign bus.cen_half = half_q;
  assign bus.cfg_busy = busy_q;
  assign bus.cfg_err  = err_q;
  assign bus.state    = state;

endmodule

// File: tb/tb_jtframe_frac_cen_ctl.sv
`timescale 1ns/1ps
module tb_jtframe_frac_cen_ctl;
  import jtframe_cen_pkg::*;

  localparam int W = 11;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int shown    = 0;

  jtframe_frac_cen_ctl_if #(.W(W)) bus ();

  jtframe_frac_cen_ctl #(.W(W), .STEP0(105), .LIM0(1408)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  // Tracks the phase as a plain integer with the published rules:
  // phase += step, every crossing of lim is one cen, config staging and
  // apply at the crossing, enable=0 clears everything.
  int m_step, m_lim, m_acc, sh_step, sh_lim, m_cnt;
  bit m_alt, m_on, m_pend;
  logic [19:0] exp_q[$];

  function automatic bit cfg_valid(input int s, input int l);
    return (s != 0) && (s <= l);
  endfunction

  task automatic model_reset();
    m_step = 105; m_lim = 1408; m_acc = 0; m_alt = 0;
    m_on = 0; m_pend = 0; m_cnt = 0; sh_step = 0; sh_lim = 0;
  endtask

  task automatic model_edge(input bit en, input bit we, input int cs, input int cl);
    bit e_cen, e_half, e_err, wrapped, illegal;
    logic [15:0] e_cnt;
    e_cen = 0; e_half = 0; e_err = 0;
    if (!m_on) begin
      if (we) begin
        if (cfg_valid(cs, cl)) begin m_step = cs; m_lim = cl; end
        else e_err = 1;
      end
      m_acc = 0; m_alt = 0; m_cnt = 0; m_on = en;
    end else if (!en) begin
      if (m_pend) begin
        m_step = sh_step; m_lim = sh_lim;
      end else if (we) begin
        if (cfg_valid(cs, cl)) begin m_step = cs; m_lim = cl; end
        else e_err = 1;
      end
      m_on = 0; m_pend = 0; m_acc = 0; m_alt = 0; m_cnt = 0;
    end else begin
      illegal = (m_acc >= m_lim + m_step);
      wrapped = 0;
      if (illegal) begin
        m_acc = 0; wrapped = 1;
      end else begin
        m_acc = m_acc + m_step;
        if (m_acc >= m_lim) begin m_acc = m_acc - m_lim; wrapped = 1; end
      end
      if (wrapped) begin
        e_cen = 1; e_half = m_alt;
        m_alt = illegal ? 1'b0 : !m_alt;
        if (m_cnt < 65535) m_cnt++;
      end
      if (m_pend) begin
        if (wrapped) begin
          m_step = sh_step; m_lim = sh_lim; m_pend = 0; m_cnt = 0;
        end
      end else if (we) begin
        if (cfg_valid(cs, cl)) begin sh_step = cs; sh_lim = cl; m_pend = 1; end
        else e_err = 1;
      end
    end
`ifdef JTFRAME_FRAC_CEN_STAT_EN
    e_cnt = 16'(m_cnt);
`else
    e_cnt = 16'd0;
`endif
    exp_q.push_back({e_cnt, e_cen, e_half, m_pend, e_err});
  endtask

  // ---------------- scoreboard ----------------
  always @(posedge clk) begin
    logic [19:0] exp_v, got_v;
    bit en_s, we_s;
    int cs_s, cl_s;
    en_s = bus.enable; we_s = bus.cfg_we;
    cs_s = int'(bus.cfg_step); cl_s = int'(bus.cfg_lim);
    if (rst) begin
      model_reset();
      exp_q.push_back(20'd0);
    end else begin
      model_edge(en_s, we_s, cs_s, cl_s);
    end
    #1;
    exp_v = exp_q.pop_front();
    got_v = {bus.cen_cnt, bus.cen, bus.cen_half, bus.cfg_busy, bus.cfg_err};
    n_checks++;
    if (got_v !== exp_v) begin
      n_fail++;
      if (shown < 10) begin
        shown++;
        $display("FAIL model_cycle t=%0t got {cnt,cen,half,busy,err}=%h expected %h",
                 $time, got_v, exp_v);
      end
    end
  end

  // ---------------- driver helpers ----------------
  task automatic tick();
    @(negedge clk);
  endtask

  task automatic wait_cen(input int limit, output int gap);
    gap = 0;
    do begin
      @(negedge clk);
      gap++;
    end while (bus.cen !== 1'b1 && gap < limit);
    if (bus.cen !== 1'b1) gap = -1;
  endtask

  function automatic int ceil_div(input int a, input int b);
    return (a + b - 1) / b;
  endfunction

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst = 1'b1;
    repeat (3) tick();
    n_checks++;
    if ({bus.cen, bus.cen_half, bus.cfg_busy, bus.cfg_err} !== 4'b0000 || bus.cen_cnt !== 16'd0) begin
      n_fail++;
      $display("FAIL reset_outputs got cen=%b half=%b busy=%b err=%b cnt=%0d expected all 0",
               bus.cen, bus.cen_half, bus.cfg_busy, bus.cfg_err, bus.cen_cnt);
    end
    n_checks++;
    if (bus.state !== OFF) begin
      n_fail++;
      $display("FAIL reset_state got %0d expected %0d", bus.state, OFF);
    end
  endtask

  task automatic test_defaults();
    int gap, n_cen, n_half, min_gap, max_gap, last;
    rst = 1'b0;
    bus.enable = 1'b1;
    wait_cen(40, gap);
    n_checks++;
    if (gap != ceil_div(1408, 105) + 1) begin
      n_fail++;
      $display("FAIL defaults_first_cen got %0d expected %0d", gap, ceil_div(1408, 105) + 1);
    end
    n_cen = 0; n_half = 0; min_gap = 100000; max_gap = 0; last = 0;
    for (int i = 1; i <= 1408; i++) begin
      tick();
      if (bus.cen === 1'b1) begin
        n_cen++;
        if (i - last < min_gap) min_gap = i - last;
        if (i - last > max_gap) max_gap = i - last;
        last = i;
      end
      if (bus.cen_half === 1'b1) n_half++;
    end
    n_checks++;
    if (n_cen != 105) begin
      n_fail++; $display("FAIL defaults_cen_count got %0d expected 105", n_cen);
    end
    n_checks++;
    if (n_half < 52 || n_half > 53) begin
      n_fail++; $display("FAIL defaults_half_count got %0d expected 52..53", n_half);
    end
    n_checks++;
    if (min_gap < 13 || max_gap > 14) begin
      n_fail++; $display("FAIL defaults_spacing got %0d..%0d expected 13..14", min_gap, max_gap);
    end
    n_checks++;
    if (bus.state !== RUN) begin
      n_fail++; $display("FAIL defaults_state got %0d expected %0d", bus.state, RUN);
    end
  endtask

  task automatic test_reconfig();
    int gap, cnt;
    wait_cen(20, gap);
    bus.cfg_we = 1'b1; bus.cfg_step = W'(1); bus.cfg_lim = W'(4);
    tick();
    bus.cfg_we = 1'b0;
    n_checks++;
    if (bus.cfg_busy !== 1'b1) begin
      n_fail++; $display("FAIL reconfig_busy_set got %b expected 1", bus.cfg_busy);
    end
    cnt = 0;
    while (bus.cfg_busy === 1'b1 && cnt < 20) begin tick(); cnt++; end
    n_checks++;
    if (bus.cfg_busy !== 1'b0 || bus.cen !== 1'b1) begin
      n_fail++;
      $display("FAIL reconfig_apply got busy=%b cen=%b after %0d clk expected busy=0 cen=1",
               bus.cfg_busy, bus.cen, cnt);
    end
    repeat (8) tick();
    wait_cen(20, gap);
    for (int i = 0; i < 10; i++) begin
      wait_cen(20, gap);
      n_checks++;
      if (gap != 4) begin
        n_fail++; $display("FAIL reconfig_gap%0d got %0d expected 4", i, gap);
      end
    end
  endtask

  task automatic test_reject();
    int n_err, n_busy, gap;
    n_err = 0; n_busy = 0;
    for (int i = 0; i < 10; i++) begin
      bus.cfg_we = (i == 0) || (i == 3);
      bus.cfg_step = (i == 0) ? W'(0) : W'(20);
      bus.cfg_lim  = (i == 0) ? W'(5) : W'(10);
      tick();
      if (bus.cfg_err === 1'b1) n_err++;
      if (bus.cfg_busy === 1'b1) n_busy++;
    end
    bus.cfg_we = 1'b0;
    n_checks++;
    if (n_err != 2) begin
      n_fail++; $display("FAIL reject_err_pulses got %0d expected 2", n_err);
    end
    n_checks++;
    if (n_busy != 0) begin
      n_fail++; $display("FAIL reject_busy got %0d busy cycles expected 0", n_busy);
    end
    wait_cen(20, gap);
    for (int i = 0; i < 5; i++) begin
      wait_cen(20, gap);
      n_checks++;
      if (gap != 4) begin
        n_fail++; $display("FAIL reject_gap%0d got %0d expected 4", i, gap);
      end
    end
  endtask

  task automatic test_every_cycle();
    int cnt, n_err;
    bit prev_half;
    bus.cfg_we = 1'b1; bus.cfg_step = W'(7); bus.cfg_lim = W'(7);
    tick();
    // Invalid write while busy must be ignored without an error.
    bus.cfg_step = W'(0); bus.cfg_lim = W'(5);
    n_checks++;
    if (bus.cfg_busy !== 1'b1) begin
      n_fail++; $display("FAIL every_busy got %b expected 1", bus.cfg_busy);
    end
    tick();
    bus.cfg_we = 1'b0;
    n_err = (bus.cfg_err === 1'b1) ? 1 : 0;
    cnt = 0;
    while (bus.cfg_busy === 1'b1 && cnt < 20) begin
      tick(); cnt++;
      if (bus.cfg_err === 1'b1) n_err++;
    end
    n_checks++;
    if (n_err != 0) begin
      n_fail++; $display("FAIL every_ignore_err got %0d pulses expected 0", n_err);
    end
    n_checks++;
    if (bus.cfg_busy !== 1'b0 || bus.cen !== 1'b1 || bus.cen_cnt !== 16'd0) begin
      n_fail++;
      $display("FAIL every_apply got busy=%b cen=%b cnt=%0d expected 0/1/0",
               bus.cfg_busy, bus.cen, bus.cen_cnt);
    end
    prev_half = bus.cen_half;
    for (int k = 1; k <= 20; k++) begin
      tick();
      n_checks++;
      if (bus.cen !== 1'b1) begin
        n_fail++; $display("FAIL every_cen%0d got %b expected 1", k, bus.cen);
      end
      if (k >= 3) begin
        n_checks++;
        if (bus.cen_half !== !prev_half) begin
          n_fail++; $display("FAIL every_half%0d got %b expected %b", k, bus.cen_half, !prev_half);
        end
      end
      prev_half = bus.cen_half;
`ifdef JTFRAME_FRAC_CEN_STAT_EN
      n_checks++;
      if (bus.cen_cnt !== 16'(k)) begin
        n_fail++; $display("FAIL every_cnt%0d got %0d expected %0d", k, bus.cen_cnt, k);
      end
`else
      n_checks++;
      if (bus.cen_cnt !== 16'd0) begin
        n_fail++; $display("FAIL every_cnt%0d got %0d expected 0", k, bus.cen_cnt);
      end
`endif
    end
  endtask

  task automatic test_rst_pend();
    int gap;
    bus.cfg_we = 1'b1; bus.cfg_step = W'(3); bus.cfg_lim = W'(50);
    tick();
    bus.cfg_we = 1'b0;
    n_checks++;
    if (bus.cfg_busy !== 1'b1) begin
      n_fail++; $display("FAIL rstpend_busy got %b expected 1", bus.cfg_busy);
    end
    #2 rst = 1'b1;
    #1;
    n_checks++;
    if ({bus.cen, bus.cen_half, bus.cfg_busy, bus.cfg_err} !== 4'b0000 ||
        bus.cen_cnt !== 16'd0 || bus.state !== OFF) begin
      n_fail++;
      $display("FAIL rstpend_async got cen=%b half=%b busy=%b err=%b cnt=%0d st=%0d expected zeros",
               bus.cen, bus.cen_half, bus.cfg_busy, bus.cfg_err, bus.cen_cnt, bus.state);
    end
    repeat (2) tick();
    rst = 1'b0;
    wait_cen(40, gap);
    n_checks++;
    if (gap != ceil_div(1408, 105) + 1) begin
      n_fail++; $display("FAIL rstpend_first_cen got %0d expected %0d", gap, ceil_div(1408, 105) + 1);
    end
    wait_cen(40, gap);
    n_checks++;
    if (gap < 13 || gap > 14) begin
      n_fail++; $display("FAIL rstpend_gap got %0d expected 13..14", gap);
    end
  endtask

  task automatic test_drop_pend();
    int gap, n_cen;
    bus.cfg_we = 1'b1; bus.cfg_step = W'(5); bus.cfg_lim = W'(23);
    tick();
    bus.cfg_we = 1'b0;
    bus.enable = 1'b0;
    n_checks++;
    if (bus.cfg_busy !== 1'b1) begin
      n_fail++; $display("FAIL drop_busy_set got %b expected 1", bus.cfg_busy);
    end
    tick();
    n_checks++;
    if (bus.cfg_busy !== 1'b0 || bus.state !== OFF) begin
      n_fail++; $display("FAIL drop_off got busy=%b st=%0d expected 0/%0d", bus.cfg_busy, bus.state, OFF);
    end
    n_cen = 0;
    repeat (5) begin tick(); if (bus.cen === 1'b1) n_cen++; end
    n_checks++;
    if (n_cen != 0) begin
      n_fail++; $display("FAIL drop_quiet got %0d cen expected 0", n_cen);
    end
    bus.enable = 1'b1;
    wait_cen(40, gap);
    n_checks++;
    if (gap != ceil_div(23, 5) + 1) begin
      n_fail++; $display("FAIL drop_first_cen got %0d expected %0d", gap, ceil_div(23, 5) + 1);
    end
    wait_cen(40, gap);
    n_checks++;
    if (gap < 4 || gap > 5) begin
      n_fail++; $display("FAIL drop_gap got %0d expected 4..5", gap);
    end
  endtask

  task automatic test_random();
    int s, l, n_cen;
    n_cen = 0;
    for (int i = 0; i < 3000; i++) begin
      if (bus.enable && $urandom_range(0, 149) == 0) bus.enable = 1'b0;
      else if (!bus.enable && $urandom_range(0, 7) == 0) bus.enable = 1'b1;
      l = ($urandom_range(0, 3) == 0) ? int'($urandom_range(100, 400)) : int'($urandom_range(1, 40));
      s = int'($urandom_range(0, 44));
      if ($urandom_range(0, 7) == 0) s = l;
      bus.cfg_we   = ($urandom_range(0, 11) == 0);
      bus.cfg_step = W'(s);
      bus.cfg_lim  = W'(l);
      tick();
      if (bus.cen === 1'b1) n_cen++;
    end
    bus.cfg_we = 1'b0;
    n_checks++;
    if (n_cen == 0) begin
      n_fail++; $display("FAIL random_activity got 0 cen expected some");
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    bus.enable = 1'b0; bus.cfg_we = 1'b0;
    bus.cfg_step = '0; bus.cfg_lim = '0;
    test_reset();
    test_defaults();
    test_reconfig();
    test_reject();
    test_every_cycle();
    test_rst_pend();
    test_drop_pend();
    test_random();
    repeat (3) tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
